// File: rtl/jk_cmd_arbiter_pkg.sv
// Shared definitions for the JK command arbiter: op encodings, FSM states,
// and the command-counter width used when JK_CMD_CNT_EN is defined.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam int unsigned CMD_CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GRANT = 2'b01,
        S_APPLY = 2'b10
    } state_t;

endpackage

// File: rtl/jk_cmd_arbiter_if.sv
// Requester-side bus of the JK command arbiter: packed per-requester commands
// in, one-hot grant and shared register state out.
interface jk_cmd_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) ();

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     cmd_op;
    logic [WIDTH*NREQ-1:0] cmd_mask;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      q;

    modport master (
        output req, cmd_op, cmd_mask,
        input  gnt, busy, done, q
    );

    modport slave (
        input  req, cmd_op, cmd_mask,
        output gnt, busy, done, q
    );

endinterface

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin pick: searches req starting at ptr, wrapping
// NREQ-1 -> 0, and reports the winner as one-hot and as an index.
module jk_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [IDXW-1:0] win_idx,
    output logic            win_valid
);

    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_valid && req[cand[IDXW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[IDXW-1:0];
            end
        end
        win_onehot = win_valid ? (NREQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin sequencer sharing one JK register bank between NREQ requesters.
// Optional macro JK_CMD_CNT_EN adds a saturating 16-bit applied-command counter.
module jk_cmd_arbiter
    import jk_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    jk_cmd_arbiter_if.slave      bus
`ifdef JK_CMD_CNT_EN
    ,
    output logic [CMD_CNT_W-1:0] cmd_cnt
`endif
);

    localparam int unsigned IDXW = $clog2(NREQ);

    state_t           state_q;
    logic [IDXW-1:0]  ptr_q;
    logic [IDXW-1:0]  widx_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [NREQ-1:0]  gnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_q;
`ifdef JK_CMD_CNT_EN
    logic [CMD_CNT_W-1:0] cnt_q;
`endif

    logic [NREQ-1:0]  win_onehot;
    logic [IDXW-1:0]  win_idx;
    logic             win_valid;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_mask;

    jk_rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req        (bus.req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    always_comb begin
        sel_op   = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                sel_op   = bus.cmd_op[2*i +: 2];
                sel_mask = bus.cmd_mask[WIDTH*i +: WIDTH];
            end
        end
    end

    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                 input logic [1:0]       op,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] nxt;
        unique case (op)
            JK_HOLD:   nxt = cur;
            JK_RESET:  nxt = cur & ~m;
            JK_SET:    nxt = cur | m;
            JK_TOGGLE: nxt = cur ^ m;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            widx_q  <= '0;
            op_q    <= '0;
            mask_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
`ifdef JK_CMD_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        op_q    <= sel_op;
                        mask_q  <= sel_mask;
                        widx_q  <= win_idx;
                        gnt_q   <= win_onehot;
                        busy_q  <= 1'b1;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    q_q     <= jk_next(q_q, op_q, mask_q);
                    ptr_q   <= (widx_q == IDXW'(NREQ - 1)) ? '0 : widx_q + IDXW'(1);
                    done_q  <= 1'b1;
                    state_q <= S_APPLY;
`ifdef JK_CMD_CNT_EN
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CMD_CNT_W'(1);
                    end
`endif
                end
                S_APPLY: begin
                    // Requests are deliberately not sampled here; IDLE owns arbitration.
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
`ifdef JK_CMD_CNT_EN
    assign cmd_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Directed bench for jk_cmd_arbiter: a transaction-level model predicts every
// cycle's outputs, and literal checks pin the model on hand-computed values.
module tb_jk_cmd_arbiter;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    jk_cmd_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();
`ifdef JK_CMD_CNT_EN
    logic [15:0] cmd_cnt;
`endif

    jk_cmd_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
`ifdef JK_CMD_CNT_EN
        ,
        .cmd_cnt (cmd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic        busy;
        logic        done;
        logic [7:0]  q;
        logic [15:0] cnt;
    } rec_t;

    rec_t        mdl_q[$];
    rec_t        exp_r = '0;
    logic [7:0]  mq = 8'h00;
    int          mptr = 0;
    logic [15:0] mcnt = 16'h0000;
    logic        last_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Each accepted request expands into three expected cycles: grant, apply, idle.
    initial begin
        int         w;
        logic [1:0] op;
        logic [7:0] m;
        logic [7:0] nq;
        rec_t       r;
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) begin
                mdl_q.delete();
                mq    = 8'h00;
                mptr  = 0;
                mcnt  = 16'h0000;
                exp_r = '0;
            end else begin
                if (mdl_q.size() == 0 && bus.req != 4'b0000) begin
                    w = -1;
                    for (int k = 0; k < 4; k++) begin
                        if (w < 0 && bus.req[(mptr + k) % 4]) w = (mptr + k) % 4;
                    end
                    op = bus.cmd_op[2*w +: 2];
                    m  = bus.cmd_mask[8*w +: 8];
                    nq = mq;
                    for (int b = 0; b < 8; b++) begin
                        if (m[b]) begin
                            if (op == 2'b01) nq[b] = 1'b0;
                            else if (op == 2'b10) nq[b] = 1'b1;
                            else if (op == 2'b11) nq[b] = ~mq[b];
                        end
                    end
                    r.gnt = 4'b0001 << w; r.busy = 1'b1; r.done = 1'b0;
                    r.q = mq; r.cnt = mcnt;
                    mdl_q.push_back(r);
                    mq = nq;
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                    mptr = (w + 1) % 4;
                    r.gnt = 4'b0000; r.done = 1'b1; r.q = mq; r.cnt = mcnt;
                    mdl_q.push_back(r);
                    r.busy = 1'b0; r.done = 1'b0;
                    mdl_q.push_back(r);
                end
                if (mdl_q.size() != 0) exp_r = mdl_q.pop_front();
                else exp_r = '{gnt: 4'b0000, busy: 1'b0, done: 1'b0, q: mq, cnt: mcnt};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_gnt", 32'(bus.gnt), 32'(exp_r.gnt));
            chk("cyc_busy", 32'(bus.busy), 32'(exp_r.busy));
            chk("cyc_done", 32'(bus.done), 32'(exp_r.done));
            chk("cyc_q", 32'(bus.q), 32'(exp_r.q));
`ifdef JK_CMD_CNT_EN
            chk("cyc_cnt", 32'(cmd_cnt), 32'(exp_r.cnt));
`endif
        end
    end

    task automatic wait_gnt(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.gnt[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL gnt_timeout: requester %0d got no grant, expected one", i);
        end
    endtask

    // Called just after a negedge; returns at the negedge of the following IDLE cycle.
    task automatic send(input int i, input logic [1:0] op, input logic [7:0] m);
        bus.req[i] = 1'b1;
        bus.cmd_op[2*i +: 2] = op;
        bus.cmd_mask[8*i +: 8] = m;
        wait_gnt(i);
        bus.req[i] = 1'b0;
        bus.cmd_op[2*i +: 2] = ~op;
        bus.cmd_mask[8*i +: 8] = ~m;
        @(negedge clk);
        last_done = bus.done;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running, expected to finish");
        $fatal(1);
    end

    initial begin
        int         log_idx[$];
        logic [3:0] reassert;
        bus.req      = 4'($urandom);
        bus.cmd_op   = 8'($urandom);
        bus.cmd_mask = 32'($urandom);
        repeat (3) @(negedge clk);
        bus.req = 4'b0000;
        clr_n   = 1'b1;
        @(negedge clk);
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);

        // Single requester 2: set low nibble.
        bus.req[2] = 1'b1;
        bus.cmd_op[5:4] = 2'b10;
        bus.cmd_mask[23:16] = 8'h0F;
        @(negedge clk);
        chk("single_gnt", 32'(bus.gnt), 32'b0100);
        chk("single_busy_g", 32'(bus.busy), 32'h1);
        bus.req[2] = 1'b0;
        @(negedge clk);
        chk("single_q", 32'(bus.q), 32'h0F);
        chk("single_done", 32'(bus.done), 32'h1);
        chk("single_busy_a", 32'(bus.busy), 32'h1);
        @(negedge clk);
        chk("single_done_off", 32'(bus.done), 32'h0);
        chk("single_busy_off", 32'(bus.busy), 32'h0);

        send(0, 2'b11, 8'hFF);
        chk("toggle_q", 32'(bus.q), 32'hF0);
        send(0, 2'b01, 8'hF0);
        chk("reset_q", 32'(bus.q), 32'h00);
        send(0, 2'b00, 8'hFF);
        chk("hold_q", 32'(bus.q), 32'h00);
        chk("hold_done", 32'(last_done), 32'h1);

        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Fairness: everyone toggles its own bit, re-requesting one cycle after release.
        bus.cmd_op   = 8'hFF;
        bus.cmd_mask = {8'h08, 8'h04, 8'h02, 8'h01};
        bus.req      = 4'hF;
        reassert     = 4'h0;
        for (int n = 0; n < 60 && log_idx.size() < 5; n++) begin
            @(negedge clk);
            bus.req  = bus.req | reassert;
            reassert = 4'h0;
            if (bus.gnt != 4'h0) begin
                for (int i = 0; i < 4; i++) if (bus.gnt[i]) log_idx.push_back(i);
                bus.req  = bus.req & ~bus.gnt;
                reassert = bus.gnt;
            end
        end
        bus.req = 4'h0;
        repeat (3) @(negedge clk);
        chk("fair_count", 32'(log_idx.size()), 32'd5);
        while (log_idx.size() < 5) log_idx.push_back(-1);
        chk("fair_0", 32'(log_idx[0]), 32'd0);
        chk("fair_1", 32'(log_idx[1]), 32'd1);
        chk("fair_2", 32'(log_idx[2]), 32'd2);
        chk("fair_3", 32'(log_idx[3]), 32'd3);
        chk("fair_4", 32'(log_idx[4]), 32'd0);
        chk("fair_q", 32'(bus.q), 32'h0E);

        // Contention after a grant to 1: requester 3 must win first.
        send(1, 2'b10, 8'h10);
        chk("pre_contend_q", 32'(bus.q), 32'h1E);
        bus.req[1] = 1'b1; bus.cmd_op[3:2] = 2'b01; bus.cmd_mask[15:8] = 8'h02;
        bus.req[3] = 1'b1; bus.cmd_op[7:6] = 2'b10; bus.cmd_mask[31:24] = 8'h80;
        @(negedge clk);
        chk("contend_first", 32'(bus.gnt), 32'b1000);
        bus.req[3] = 1'b0;
        repeat (2) @(negedge clk);
        chk("contend_q3", 32'(bus.q), 32'h9E);
        @(negedge clk);
        chk("contend_second", 32'(bus.gnt), 32'b0010);
        bus.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("contend_q1", 32'(bus.q), 32'h9C);

        // Late drop with scrambled op/mask after grant.
        send(2, 2'b11, 8'h0F);
        chk("late_drop_q", 32'(bus.q), 32'h93);

        // Abort in GRANT.
        bus.req[0] = 1'b1; bus.cmd_op[1:0] = 2'b10; bus.cmd_mask[7:0] = 8'hFF;
        @(negedge clk);
        chk("abort_gnt", 32'(bus.gnt), 32'b0001);
        #2;
        clr_n   = 1'b0;
        bus.req = 4'h0;
        #1;
        chk("abort_q", 32'(bus.q), 32'h00);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_gnt_off", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", 32'(bus.done), 32'h0);
        chk("abort_q_after", 32'(bus.q), 32'h00);

        // Five commands from a clean reset: 0 ->FF ->0F ->0A ->0A ->5A.
        send(0, 2'b10, 8'hFF);
        send(1, 2'b01, 8'hF0);
        send(2, 2'b11, 8'h05);
        send(3, 2'b00, 8'hFF);
        send(0, 2'b11, 8'h50);
        chk("five_q", 32'(bus.q), 32'h5A);
`ifdef JK_CMD_CNT_EN
        chk("five_cnt", 32'(cmd_cnt), 32'd5);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
